program_sequencer: RTL and testbench

//  Sequences the RISC core for button-selected programs: arbitrates debounced requests (fib/sort/save/load),

---
 rtl/risc_pkg.sv | 18 +
 rtl/req_priority_edge.sv | 28 ++
 rtl/program_sequencer.sv | 108 ++++++++++
 tb/tb_program_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared types and codes for the program sequencer.
package risc_pkg;
   typedef enum logic [2:0] {IDLE, HOLD, CRST, RUN, DONE} state_t;
   localparam logic [2:0] PROG_NONE = 3'd0;
   localparam logic [2:0] PROG_FIB  = 3'd1;
   localparam logic [2:0] PROG_SORT = 3'd2;
   localparam logic [2:0] PROG_SAVE = 3'd3;
   localparam logic [2:0] PROG_LOAD = 3'd4;
   localparam logic [1:0] ST_NONE    = 2'd0;
   localparam logic [1:0] ST_OK      = 2'd1;
   localparam logic [1:0] ST_ABORT   = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction
endpackage

// File: rtl/req_priority_edge.sv
// req_priority_edge: registered rising-edge detect on button levels with fixed fib>sort>save>load priority.
module req_priority_edge
   import risc_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] req,
   output logic       valid,
   output logic [2:0] code
);
   logic [3:0] req_q;
   logic [3:0] rise;
   assign rise = req & ~req_q;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_q <= '0;
         valid <= 1'b0;
         code  <= PROG_NONE;
      end else begin
         req_q <= req;
         valid <= |rise;
         code  <= rise[0] ? PROG_FIB  :
                  rise[1] ? PROG_SORT :
                  rise[2] ? PROG_SAVE :
                  rise[3] ? PROG_LOAD : PROG_NONE;
      end
   end
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: runs a button-selected program on the core: selector hold, core reset pulse,
// then run until halt, abort or watchdog timeout.
module program_sequencer
   import risc_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int RST_CYCLES  = 2,
   parameter int TIMEOUT     = 1048576,
   parameter int SEL_W       = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [3:0]       req,
   input  logic             abort,
   input  logic             cpu_halt,
   output logic [SEL_W-1:0] prog_sel,
   output logic             cpu_reset,
   output logic             cpu_run,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status
);
   localparam int CW = $clog2(max3(HOLD_CYCLES, RST_CYCLES, TIMEOUT)) + 1;
   state_t        state, nxt;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [2:0]    code, code_q, nxt_code;
   logic [1:0]    nxt_status;
   logic          valid;
   req_priority_edge u_req (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req),
      .valid   (valid),
      .code    (code)
   );
   always_comb begin
      nxt        = state;
      nxt_cnt    = cnt + 1'b1;
      nxt_status = status;
      nxt_code   = code_q;
      case (state)
         IDLE: begin
            nxt_cnt = '0;
            if (valid) begin
               nxt        = HOLD;
               nxt_code   = code;
               nxt_status = ST_NONE;
            end
         end
         HOLD:
            if (abort) begin
               nxt        = DONE;
               nxt_status = ST_ABORT;
            end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
               nxt     = CRST;
               nxt_cnt = '0;
            end
         CRST:
            if (abort) begin
               nxt        = DONE;
               nxt_status = ST_ABORT;
            end else if (cnt == CW'(RST_CYCLES - 1)) begin
               nxt     = RUN;
               nxt_cnt = '0;
            end
         RUN:
            if (cpu_halt) begin
               nxt        = DONE;
               nxt_status = ST_OK;
            end else if (abort) begin
               nxt        = DONE;
               nxt_status = ST_ABORT;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               nxt        = DONE;
               nxt_status = ST_TIMEOUT;
            end
         DONE: begin
            nxt     = IDLE;
            nxt_cnt = '0;
         end
         default: nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         code_q    <= PROG_NONE;
         status    <= ST_NONE;
         prog_sel  <= '0;
         cpu_reset <= 1'b1;
         cpu_run   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= nxt;
         cnt       <= nxt_cnt;
         code_q    <= nxt_code;
         status    <= nxt_status;
         prog_sel  <= (nxt == HOLD) ? SEL_W'(nxt_code) : '0;
         cpu_reset <= nxt != RUN;
         cpu_run   <= nxt == RUN;
         busy      <= nxt != IDLE;
         done      <= nxt == DONE;
      end
   end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed checks of request arbitration, hold/reset/run sequencing and stop causes.
module tb_program_sequencer;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic        abort = 1'b0;
   logic        cpu_halt = 1'b0;
   logic [31:0] prog_sel;
   logic        cpu_reset, cpu_run, busy, done;
   logic [1:0]  status;
   int          errors = 0;
   int          checks = 0;
   program_sequencer #(.HOLD_CYCLES(4), .RST_CYCLES(2), .TIMEOUT(16), .SEL_W(32)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .abort     (abort),
      .cpu_halt  (cpu_halt),
      .prog_sel  (prog_sel),
      .cpu_reset (cpu_reset),
      .cpu_run   (cpu_run),
      .busy      (busy),
      .done      (done),
      .status    (status)
   );
   always #5 clock = ~clock;
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      tick(2);
      chk("rst_sel", prog_sel, 0);
      chk("rst_creset", 32'(cpu_reset), 1);
      chk("rst_run", 32'(cpu_run), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_status", 32'(status), 0);
      reset_n = 1'b1;
      tick(2);
      // fib normal run
      req = 4'b0001;
      tick(1);
      chk("fib_idle", 32'(busy), 0);
      tick(1);
      chk("fib_sel0", prog_sel, 1);
      chk("fib_busy", 32'(busy), 1);
      chk("fib_hold_creset", 32'(cpu_reset), 1);
      for (int i = 1; i < 4; i++) begin
         tick(1);
         chk("fib_sel_hold", prog_sel, 1);
      end
      tick(1);
      chk("fib_crst_sel", prog_sel, 0);
      chk("fib_crst_creset", 32'(cpu_reset), 1);
      tick(1);
      chk("fib_crst_run", 32'(cpu_run), 0);
      tick(1);
      chk("fib_run", 32'(cpu_run), 1);
      chk("fib_run_creset", 32'(cpu_reset), 0);
      tick(4);
      chk("fib_run5", 32'(cpu_run), 1);
      cpu_halt = 1'b1;
      tick(1);
      cpu_halt = 1'b0;
      chk("fib_done", 32'(done), 1);
      chk("fib_status", 32'(status), 1);
      chk("fib_done_run", 32'(cpu_run), 0);
      chk("fib_done_creset", 32'(cpu_reset), 1);
      tick(1);
      chk("fib_done_pulse", 32'(done), 0);
      chk("fib_idle_busy", 32'(busy), 0);
      chk("fib_status_held", 32'(status), 1);
      req = 4'b0000;
      tick(2);
      // priority with load held through the sort run
      req = 4'b1110;
      tick(2);
      chk("prio_sel", prog_sel, 2);
      chk("prio_status_clr", 32'(status), 0);
      tick(6);
      chk("sort_run", 32'(cpu_run), 1);
      cpu_halt = 1'b1;
      tick(1);
      cpu_halt = 1'b0;
      chk("sort_status", 32'(status), 1);
      req = 4'b1000;
      tick(5);
      chk("held_no_busy", 32'(busy), 0);
      chk("held_no_sel", prog_sel, 0);
      req = 4'b0000;
      tick(1);
      req = 4'b1000;
      tick(2);
      chk("load_sel", prog_sel, 4);
      // abort during hold
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abort_done", 32'(done), 1);
      chk("abort_status", 32'(status), 2);
      chk("abort_run", 32'(cpu_run), 0);
      chk("abort_sel", prog_sel, 0);
      tick(1);
      chk("abort_idle", 32'(busy), 0);
      chk("abort_never_ran", 32'(cpu_run), 0);
      // halt beats abort in the same run cycle
      req = 4'b0001;
      tick(2);
      chk("ha_sel", prog_sel, 1);
      tick(6);
      chk("ha_run", 32'(cpu_run), 1);
      abort = 1'b1;
      cpu_halt = 1'b1;
      tick(1);
      cpu_halt = 1'b0;
      chk("ha_status", 32'(status), 1);
      chk("ha_done", 32'(done), 1);
      tick(2);
      abort = 1'b0;
      chk("idle_abort_busy", 32'(busy), 0);
      chk("idle_abort_status", 32'(status), 1);
      // timeout, with a sort press ignored while busy
      req = 4'b0000;
      tick(1);
      req = 4'b0001;
      tick(8);
      chk("to_run_first", 32'(cpu_run), 1);
      req = 4'b0011;
      tick(14);
      chk("to_run15", 32'(cpu_run), 1);
      chk("to_status_run", 32'(status), 0);
      tick(1);
      chk("to_run16", 32'(cpu_run), 1);
      tick(1);
      chk("to_done", 32'(done), 1);
      chk("to_status", 32'(status), 3);
      chk("to_run_off", 32'(cpu_run), 0);
      tick(4);
      chk("busy_req_dropped", 32'(busy), 0);
      chk("busy_req_sel", prog_sel, 0);
      // async reset mid-run
      req = 4'b0000;
      tick(1);
      req = 4'b0100;
      tick(8);
      chk("rr_sel_seen", 32'(cpu_run), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rr_run", 32'(cpu_run), 0);
      chk("rr_creset", 32'(cpu_reset), 1);
      chk("rr_sel", prog_sel, 0);
      chk("rr_busy", 32'(busy), 0);
      chk("rr_status", 32'(status), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
